// File: rtl/bcd_line_formatter.sv
// Serialises a latched BCD reading into an ASCII line (digits, optional '.', CR, LF),
// handing one byte at a time to a UART transmitter via a start/busy handshake.
module bcd_line_formatter #(
  parameter int unsigned NUMBER_OF_NYBBLES      = 8,
  parameter int unsigned DP_POSITION            = 0,
  parameter int unsigned SUPPRESS_LEADING_ZEROS = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [4*NUMBER_OF_NYBBLES-1:0] bcd,
  input  logic                           bcd_valid,
  input  logic                           uart_busy,
  output logic                           start_uart_transfer,
  output logic [7:0]                     byte_to_send,
  output logic                           busy,
  output logic                           dropped
);

  localparam int unsigned HasDp    = (DP_POSITION > 0) ? 1 : 0;
  localparam int unsigned NumSlots = NUMBER_OF_NYBBLES + HasDp + 2;
  localparam int unsigned IdxW     = $clog2(NumSlots);
  localparam int unsigned Forced   = (DP_POSITION > 0) ? NUMBER_OF_NYBBLES - DP_POSITION - 1
                                                       : NUMBER_OF_NYBBLES - 1;

  localparam logic [IdxW-1:0] DpSlot     = IdxW'(NUMBER_OF_NYBBLES - DP_POSITION);
  localparam logic [IdxW-1:0] CrSlot     = IdxW'(NUMBER_OF_NYBBLES + HasDp);
  localparam logic [IdxW-1:0] LfSlot     = IdxW'(NUMBER_OF_NYBBLES + HasDp + 1);
  localparam logic [IdxW-1:0] ForcedIdx  = IdxW'(Forced);

  typedef enum logic [2:0] {StIdle, StPrep, StStrobe, StGuard, StWait} state_e;

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [4*NUMBER_OF_NYBBLES-1:0] shadow_q, shadow_d;
  logic                           leading_q, leading_d;
  logic [7:0]                     byte_q, byte_d;
  logic                           start_q, start_d;
  logic                           dropped_q, dropped_d;
  logic                           busy_q, busy_d;

  logic            is_dp, is_cr, is_lf, is_digit, suppress;
  logic [IdxW-1:0] digit_idx;
  logic [3:0]      nyb;
  logic [7:0]      slot_char;

  // Slot decode: digits fill every slot except the '.' slot, then CR, LF.
  always_comb begin
    is_dp     = (HasDp != 0) && (idx_q == DpSlot);
    is_cr     = (idx_q == CrSlot);
    is_lf     = (idx_q == LfSlot);
    is_digit  = !is_dp && !is_cr && !is_lf;
    digit_idx = ((HasDp != 0) && (idx_q > DpSlot)) ? idx_q - 1'b1 : idx_q;
    nyb       = 4'h0;
    for (int k = 0; k < NUMBER_OF_NYBBLES; k++) begin
      if (digit_idx == IdxW'(k)) nyb = shadow_q[4*(NUMBER_OF_NYBBLES-1-k) +: 4];
    end
    suppress = (SUPPRESS_LEADING_ZEROS != 0) && leading_q && is_digit &&
               (nyb == 4'h0) && (digit_idx != ForcedIdx);
    if (is_cr)           slot_char = 8'h0d;
    else if (is_lf)      slot_char = 8'h0a;
    else if (is_dp)      slot_char = 8'h2e;
    else if (nyb > 4'h9) slot_char = 8'h3f;
    else                 slot_char = {4'h3, nyb};
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    leading_d = leading_q;
    byte_d    = byte_q;
    start_d   = 1'b0;
    dropped_d = bcd_valid && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (bcd_valid) begin
          shadow_d  = bcd;
          idx_d     = '0;
          leading_d = 1'b1;
          state_d   = StPrep;
        end
      end
      StPrep: begin
        if (suppress) begin
          idx_d = idx_q + 1'b1;
        end else begin
          byte_d  = slot_char;
          state_d = StStrobe;
          if (is_digit) leading_d = 1'b0;
        end
      end
      StStrobe: begin
        if (!uart_busy) begin
          start_d = 1'b1;
          state_d = StGuard;
        end
      end
      // One dead cycle so the transmitter can raise busy before we look at it.
      StGuard: state_d = StWait;
      StWait: begin
        if (!uart_busy) begin
          if (is_lf) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StPrep;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      shadow_q  <= '0;
      leading_q <= 1'b0;
      byte_q    <= 8'h00;
      start_q   <= 1'b0;
      dropped_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      leading_q <= leading_d;
      byte_q    <= byte_d;
      start_q   <= start_d;
      dropped_q <= dropped_d;
      busy_q    <= busy_d;
    end
  end

  assign start_uart_transfer = start_q;
  assign byte_to_send        = byte_q;
  assign busy                = busy_q;
  assign dropped             = dropped_q;

endmodule

// File: doc/bcd_line_formatter.md
# bcd_line_formatter

Serialises one latched BCD frequency reading into an ASCII text line (digits, optional decimal point, CR, LF) for a byte-wide UART transmitter. It sits downstream of the hex2bcd stage in the frequency-counter top, beside the segmented display driver. It consumes the same buffered BCD word, plus a one-cycle strobe, and drives the UART's start/busy handshake one byte at a time.

## Interface
- NUMBER_OF_NYBBLES, 8: BCD digits in `bcd`, most significant nybble first; legal range 1..8.
- DP_POSITION, 0: digits to the right of the decimal point; 0 means no '.' is emitted; legal range 0..NUMBER_OF_NYBBLES-1.
- SUPPRESS_LEADING_ZEROS, 1: 1 means leading zero digits are skipped.
- clock  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- bcd  input  4*NUMBER_OF_NYBBLES  reading to print; sampled only when `bcd_valid` is accepted.
- bcd_valid  input  1  one-cycle strobe: new reading available.
- uart_busy  input  1  transmitter is shifting a byte.
- start_uart_transfer  output  1  registered one-cycle pulse: transmitter loads `byte_to_send`.
- byte_to_send  output  8  character presented to the transmitter.
- busy  output  1  high from acceptance of `bcd_valid` until the LF byte completes.
- dropped  output  1  one-cycle pulse when `bcd_valid` arrives while `busy`.

## Operation
- Line format: slot sequence is digits (MSB first), then '.' (0x2e) inserted before the last DP_POSITION digits when DP_POSITION>0, then 0x0d, then 0x0a. Total slots = NUMBER_OF_NYBBLES + (DP_POSITION>0) + 2.
- Digit encoding: nybble 0..9 maps to {4'h3, nybble}. Nybble A..F maps to '?' (0x3f) and counts as nonzero for suppression.
- Leading-zero suppression (when enabled): skip zero digits until the first nonzero digit. Never skip the last digit. Never skip the digit immediately left of '.'. All-zero input therefore prints "0" or "0.000…".
- States: IDLE, PREP, STROBE, GUARD, WAIT.
  - IDLE: `busy`=0. On `bcd_valid`, latch `bcd` into the shadow register, set slot index 0, go to PREP.
  - PREP: evaluate the slot. If it is suppressed, increment the index and stay in PREP (one cycle per skipped slot). Otherwise load `byte_to_send` and go to STROBE.
  - STROBE: if `uart_busy`=0, pulse `start_uart_transfer` and go to GUARD. Otherwise hold.
  - GUARD: exactly one cycle, giving the transmitter time to raise busy. Then go to WAIT.
  - WAIT: when `uart_busy`=0, go to IDLE if the slot was LF; otherwise increment the index and go to PREP.
- `byte_to_send` changes only in PREP. It is stable from the cycle before `start_uart_transfer` until `uart_busy` falls.
- `bcd_valid` outside IDLE is ignored. It pulses `dropped` the next cycle, and the shadow register and line in progress are unchanged.
- `bcd_valid` in the same cycle as LF completion (WAIT to IDLE) is dropped. Acceptance happens only while the state is IDLE.

## Timing
- Reset values: `start_uart_transfer`=0, `byte_to_send`=0x00, `busy`=0, `dropped`=0, state IDLE, index 0.
- Reset mid-line: on the next edge, all outputs return to reset values and the partial line is abandoned. A byte already started in the transmitter is not recalled.
- Latency with `uart_busy` low:
  - Edge E samples `bcd_valid`, and `busy` rises at E.
  - `start_uart_transfer` is high during the cycle following edge E+2+S, where S is the number of suppressed slots.
- Per-byte overhead beyond the UART's own busy time: 3 cycles (PREP, STROBE, GUARD), plus 1 cycle to observe `uart_busy` low in WAIT.
- `busy` falls on the edge where WAIT sees `uart_busy`=0 after LF. A new `bcd_valid` is accepted from the following cycle.
- `start_uart_transfer` is never high on two consecutive cycles. It is never high while `uart_busy` is sampled high.

## Test plan
- Default parameters, DP_POSITION=0, bcd=0x12345678, UART model busy for 10 cycles per byte -> bytes 31 32 33 34 35 36 37 38 0d 0a, exactly 10 start pulses, then `busy` falls.
- DP_POSITION=6, bcd=0x00123456 -> "0.123456" CR LF (bytes 30 2e 31 32 33 34 35 36 0d 0a); first start pulse 3 edges after acceptance (S=1).
- bcd=0x00000000, DP_POSITION=0 -> 30 0d 0a; with SUPPRESS_LEADING_ZEROS=0 -> eight 0x30, then 0d 0a.
- Second `bcd_valid` (bcd=0x99999999) during the 4th byte of a line -> `dropped` pulses once and the line continues unchanged. A strobe after `busy` falls prints 39×8 0d 0a.
- `uart_busy` held high 200 cycles after a start -> no further start pulse and `byte_to_send` constant. Resume 4 cycles after busy falls.
- Reset asserted during byte 5 -> next edge: all outputs 0 and IDLE. A following `bcd_valid` with bcd=0x0000000a prints 3f 0d 0a.
